// File: rtl/snn_step_scheduler.sv
// snn_step_scheduler: drives one inference of an N-neuron layer.
// It emits TS time_step pulses, then merges one result record per neuron
// onto a single round-robin AXI-stream towards the host.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// RUN    | issuing time_step pulses, one every STEP_CYCLES cycles
// WAIT   | 3 settle cycles so neurons see the last time_step fall
// DRAIN  | round-robin collection of one record per neuron
// DONE   | one-cycle done pulse, then back to IDLE
module snn_step_scheduler #(
  parameter int N           = 4,
  parameter int DW          = 8,
  parameter int UW          = 5,
  parameter int TS          = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      time_step,
  output logic [$clog2(TS+1)-1:0]   step_count,
  input  logic [N-1:0]              in_tvalid,
  output logic [N-1:0]              in_tready,
  input  logic [N*DW-1:0]           in_tdata,
  input  logic [N*UW-1:0]           in_tuser,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic [DW-1:0]             out_tdata,
  output logic [UW-1:0]             out_tuser,
  output logic [$clog2(N)-1:0]      out_tid,
  output logic                      out_tlast
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam int SW = $clog2(TS+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [SW-1:0]   step_q, step_d;
  logic [N-1:0]    served_q, served_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            gvld_q, gvld_d;
  logic            last_q, last_d;

  logic [N-1:0]    cand;
  logic            found;
  logic [IW-1:0]   pick;

  // Round-robin search over unserved valid sources, starting at the rr pointer.
  always_comb begin
    cand  = in_tvalid & ~served_q;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && cand[(int'(rr_q) + k) % N]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_q) + k) % N);
      end
    end
  end

  // Next-state and Moore/handshake outputs.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    step_d     = step_q;
    served_d   = served_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    gvld_d     = gvld_q;
    last_d     = last_q;
    busy       = 1'b0;
    done       = 1'b0;
    time_step  = 1'b0;
    out_tvalid = 1'b0;
    in_tready  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cyc_d    = '0;
          step_d   = '0;
          served_d = '0;
          gvld_d   = 1'b0;
          last_d   = 1'b0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cyc_q == CW'(STEP_CYCLES-1)) begin
          time_step = 1'b1;
          cyc_d     = '0;
          if (step_q != SW'(TS)) step_d = step_q + 1'b1;
          if (step_q == SW'(TS-1)) state_d = S_WAIT;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cyc_q == CW'(2)) begin
          cyc_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy       = 1'b1;
        out_tvalid = gvld_q;
        // A grant is only selected while none is outstanding, so the served
        // update of a handshake always lands before the next selection.
        if (gvld_q && out_tready) begin
          in_tready[gnt_q] = 1'b1;
          served_d[gnt_q]  = 1'b1;
          rr_d             = (int'(gnt_q) == N-1) ? '0 : gnt_q + 1'b1;
          gvld_d           = 1'b0;
          last_d           = 1'b0;
          if (last_q) state_d = S_DONE;
        end else if (!gvld_q && found) begin
          gvld_d = 1'b1;
          gnt_d  = pick;
          last_d = ($countones(served_q) == N-1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Payload follows the granted source; zero whenever nothing is offered.
  always_comb begin
    out_tdata = '0;
    out_tuser = '0;
    out_tid   = '0;
    out_tlast = 1'b0;
    if (out_tvalid) begin
      out_tdata = in_tdata[int'(gnt_q)*DW +: DW];
      out_tuser = in_tuser[int'(gnt_q)*UW +: UW];
      out_tid   = gnt_q;
      out_tlast = last_q;
    end
  end

  assign step_count = step_q;

  // State and counter registers; reset aborts any inference without done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      step_q   <= '0;
      served_q <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      gvld_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      step_q   <= step_d;
      served_q <= served_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      gvld_q   <= gvld_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Testbench for snn_step_scheduler: step timing table plus drain sequences.
module tb_snn_step_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done, time_step;
  logic [4:0]  step_count;
  logic [3:0]  in_tvalid, in_tready;
  logic [31:0] in_tdata;
  logic [19:0] in_tuser;
  logic        out_tvalid, out_tready;
  logic [7:0]  out_tdata;
  logic [4:0]  out_tuser;
  logic [1:0]  out_tid;
  logic        out_tlast;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cnt = 0;

  snn_step_scheduler dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .time_step(time_step), .step_count(step_count),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tuser(in_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tuser(out_tuser), .out_tid(out_tid), .out_tlast(out_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cycle;
    logic       drive_start;
    logic       exp_ts;
    logic       exp_busy;
    logic [4:0] exp_step;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (time_step) pulse_cnt++;
  endtask

  task automatic start_inf();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    repeat (131) tick();
  endtask

  // Collects records in DRAIN with a simple source model: a neuron's valid
  // rises at its arrival offset and drops after its record is accepted.
  task automatic drain_run(input string nm, input logic [3:0] pend0, input int arr[4],
                           input int exp_tid[4], input int nexp, input int last_idx,
                           input logic start_in_done);
    logic [3:0] pending;
    int nrec, ndone, g;
    logic hs;
    pending = pend0;
    nrec = 0;
    ndone = 0;
    for (int k = 0; k < 200 && ndone == 0; k++) begin
      for (int i = 0; i < 4; i++) if (arr[i] == k) pending[i] = 1'b1;
      in_tvalid = pending;
      #1;
      hs = out_tvalid & out_tready;
      g = int'(out_tid);
      if (hs) begin
        chk({nm, " in_tready"}, {28'd0, in_tready}, 32'd1 << g);
        chk({nm, " tdata"}, {24'd0, out_tdata}, 32'hA0 + g);
        chk({nm, " tuser"}, {27'd0, out_tuser}, g + 3);
        if (nrec < nexp) chk({nm, " tid order"}, g, exp_tid[nrec]);
        chk({nm, " tlast"}, {31'd0, out_tlast}, (nrec == last_idx) ? 1 : 0);
        nrec++;
      end else if (in_tready != 4'd0) begin
        chk({nm, " idle in_tready"}, {28'd0, in_tready}, 32'd0);
      end
      if (done) begin
        ndone++;
        if (start_in_done) start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (hs) pending[g] = 1'b0;
    end
    chk({nm, " done seen"}, ndone, 1);
    chk({nm, " record count"}, nrec, nexp);
    chk({nm, " done one cycle"}, {31'd0, done}, 32'd0);
    in_tvalid = 4'd0;
  endtask

  initial begin
    int arr[4];
    int exp[4];
    reset_n = 1'b0;
    start = 1'b0;
    in_tvalid = 4'd0;
    out_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_tdata[i*8 +: 8] = 8'(8'hA0 + i);
      in_tuser[i*5 +: 5] = 5'(i + 3);
    end

    vecs[0]  = '{1,   1'b0, 1'b0, 1'b1, 5'd0};
    vecs[1]  = '{7,   1'b0, 1'b0, 1'b1, 5'd0};
    vecs[2]  = '{8,   1'b0, 1'b1, 1'b1, 5'd0};
    vecs[3]  = '{9,   1'b0, 1'b0, 1'b1, 5'd1};
    vecs[4]  = '{16,  1'b0, 1'b1, 1'b1, 5'd1};
    vecs[5]  = '{17,  1'b0, 1'b0, 1'b1, 5'd2};
    vecs[6]  = '{50,  1'b1, 1'b0, 1'b1, 5'd6};
    vecs[7]  = '{127, 1'b0, 1'b0, 1'b1, 5'd15};
    vecs[8]  = '{128, 1'b0, 1'b1, 1'b1, 5'd15};
    vecs[9]  = '{129, 1'b0, 1'b0, 1'b1, 5'd16};
    vecs[10] = '{131, 1'b0, 1'b0, 1'b1, 5'd16};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset outputs", {done, time_step, step_count, out_tvalid, in_tready, out_tdata,
                          out_tuser, out_tid, out_tlast}, 0);
    reset_n = 1'b1;
    tick();

    // T1 + T6 (start during RUN)
    pulse_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    pulse_cnt = 0;
    if (time_step) pulse_cnt++;
    for (int v = 0; v < 11; v++) begin
      while (cyc < vecs[v].cycle) tick();
      chk($sformatf("T1 time_step c%0d", vecs[v].cycle), {31'd0, time_step}, {31'd0, vecs[v].exp_ts});
      chk($sformatf("T1 busy c%0d", vecs[v].cycle), {31'd0, busy}, {31'd0, vecs[v].exp_busy});
      chk($sformatf("T1 step_count c%0d", vecs[v].cycle), {27'd0, step_count}, {27'd0, vecs[v].exp_step});
      if (vecs[v].drive_start) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    // T2: all valid, ready always high; start pulsed in DONE
    in_tvalid = 4'hF;
    out_tready = 1'b1;
    tick();
    chk("T2 no grant at drain entry", {31'd0, out_tvalid}, 0);
    arr = '{-1, -1, -1, -1};
    exp = '{0, 1, 2, 3};
    drain_run("T2", 4'hF, arr, exp, 4, 3, 1'b1);
    chk("T6 pulse total", pulse_cnt, 16);
    repeat (4) tick();
    chk("T6 idle after start in DONE", {31'd0, busy}, 0);
    chk("T6 no extra pulses", pulse_cnt, 16);

    // T3: sparse arrivals
    start_inf();
    arr = '{10, 20, 0, 20};
    exp = '{2, 0, 1, 3};
    drain_run("T3", 4'h0, arr, exp, 4, 3, 1'b0);

    // T4: back-pressure on the first grant
    start_inf();
    out_tready = 1'b0;
    in_tvalid = 4'hF;
    tick();
    for (int h = 0; h < 5; h++) begin
      chk("T4 stall valid", {31'd0, out_tvalid}, 1);
      chk("T4 stall payload", {out_tid, out_tdata, out_tuser}, {2'd0, 8'hA0, 5'd3});
      chk("T4 stall in_tready", {28'd0, in_tready}, 0);
      tick();
    end
    out_tready = 1'b1;
    #1;
    chk("T4 accept in_tready", {28'd0, in_tready}, 32'h1);
    chk("T4 accept tid", {30'd0, out_tid}, 0);
    tick();
    arr = '{-1, -1, -1, -1};
    exp = '{1, 2, 3, 0};
    drain_run("T4", 4'hE, arr, exp, 3, 2, 1'b0);

    // T5: reset at the 5th pulse
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int budget;
      budget = 0;
      while (!(time_step && step_count == 5'd4) && budget < 100) begin
        tick();
        budget++;
      end
      chk("T5 reached 5th pulse", budget < 100 ? 1 : 0, 1);
    end
    reset_n = 1'b0;
    #1;
    chk("T5 outputs after reset", {busy, done, time_step, step_count, out_tvalid, in_tready}, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("T5 no done in reset", {31'd0, done}, 0);
    end
    reset_n = 1'b1;
    tick();
    chk("T5 idle after reset", {31'd0, busy}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("T5 fresh step_count", {27'd0, step_count}, 0);
    while (cyc < 8) tick();
    chk("T5 first pulse", {31'd0, time_step}, 1);
    tick();
    chk("T5 step_count after first pulse", {27'd0, step_count}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
